cpu_id_stage: RTL and testbench

Registered, parametrised instruction-decode stage for the MIPS pipeline, sitting between IF and EX. It holds one instruction in a decode slot with valid/ready handshakes on both sides. Operands are forwarded from `NUM_FWD` prioritised write-back channels. Load-use hazards are detected and bubbles inserted, and a saturating stall counter is maintained. Decoded operation and operands go to EX through an output pipeline register.

---
 rtl/cpu_id_stage_if.sv | 56 +++++
 rtl/cpu_id_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_cpu_id_stage.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_id_stage_if.sv
// Shared operation encoding plus the IF/EX handshake bundle of the decode stage.
// master is the decode stage side, slave is the pipeline environment around it.
package cpu_id_pkg;
  typedef enum logic [4:0] {
    OP_INVALID = 5'd0,
    OP_ADDU,
    OP_SUBU,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ADDIU,
    OP_SLTI,
    OP_SLTIU,
    OP_LW,
    OP_ANDI,
    OP_ORI,
    OP_XORI,
    OP_LUI,
    OP_J,
    OP_JAL
  } Oper_t;
endpackage

interface cpu_id_stage_if;
  import cpu_id_pkg::*;

  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  Oper_t       ex_op;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic        ex_we;
  logic [4:0]  ex_waddr;

  modport master (
    input  if_valid, if_pc, if_inst, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_op, ex_reg1, ex_reg2, ex_we, ex_waddr
  );

  modport slave (
    output if_valid, if_pc, if_inst, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_op, ex_reg1, ex_reg2, ex_we, ex_waddr
  );
endinterface

// File: rtl/cpu_id_stage.sv
// MIPS instruction-decode stage: one-entry decode slot, prioritised operand forwarding,
// load-use stall detection with a saturating stall counter, and a registered EX output.
module cpu_id_stage
  import cpu_id_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  cpu_id_stage_if.master       bus,
  output logic [4:0]           reg_raddr1,
  output logic [4:0]           reg_raddr2,
  input  logic [31:0]          reg1_i,
  input  logic [31:0]          reg2_i,
  input  logic [NUM_FWD-1:0]   fwd_we,
  input  logic [NUM_FWD*5-1:0] fwd_waddr,
  input  logic [NUM_FWD*32-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]   fwd_is_load,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic        slot_valid;
  logic [31:0] slot_pc;
  logic [31:0] slot_inst;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm;

  assign opcode = slot_inst[31:26];
  assign rs     = slot_inst[25:21];
  assign rt     = slot_inst[20:16];
  assign rd     = slot_inst[15:11];
  assign sa     = slot_inst[10:6];
  assign funct  = slot_inst[5:0];
  assign imm    = slot_inst[15:0];

  assign reg_raddr1 = rs;
  assign reg_raddr2 = rt;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rs_load;
  logic        rt_load;

  // Walk from the oldest channel to the youngest so channel 0 has the final say.
  always_comb begin
    rs_val  = '0;
    rt_val  = '0;
    rs_load = 1'b0;
    rt_load = 1'b0;
    if (rs != 5'd0) rs_val = reg1_i;
    if (rt != 5'd0) rt_val = reg2_i;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && rs != 5'd0 && fwd_waddr[5*i +: 5] == rs) begin
        rs_val  = fwd_wdata[32*i +: 32];
        rs_load = fwd_is_load[i];
      end
      if (fwd_we[i] && rt != 5'd0 && fwd_waddr[5*i +: 5] == rt) begin
        rt_val  = fwd_wdata[32*i +: 32];
        rt_load = fwd_is_load[i];
      end
    end
  end

  Oper_t dec_op;

  always_comb begin
    dec_op = OP_INVALID;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   dec_op = OP_ADDU;
          6'h23:   dec_op = OP_SUBU;
          6'h24:   dec_op = OP_AND;
          6'h25:   dec_op = OP_OR;
          6'h26:   dec_op = OP_XOR;
          6'h27:   dec_op = OP_NOR;
          6'h2A:   dec_op = OP_SLT;
          6'h2B:   dec_op = OP_SLTU;
          6'h00:   dec_op = OP_SLL;
          6'h02:   dec_op = OP_SRL;
          6'h03:   dec_op = OP_SRA;
          default: dec_op = OP_INVALID;
        endcase
      end
      6'h02:   dec_op = OP_J;
      6'h03:   dec_op = OP_JAL;
      6'h09:   dec_op = OP_ADDIU;
      6'h0A:   dec_op = OP_SLTI;
      6'h0B:   dec_op = OP_SLTIU;
      6'h0C:   dec_op = OP_ANDI;
      6'h0D:   dec_op = OP_ORI;
      6'h0E:   dec_op = OP_XORI;
      6'h0F:   dec_op = OP_LUI;
      6'h23:   dec_op = OP_LW;
      default: dec_op = OP_INVALID;
    endcase
  end

  logic [31:0] dec_reg1;
  logic [31:0] dec_reg2;
  logic [4:0]  dec_waddr;
  logic        dec_wen;
  logic        dec_we;
  logic        use_rs;
  logic        use_rt;

  always_comb begin
    dec_reg1  = '0;
    dec_reg2  = '0;
    dec_waddr = '0;
    dec_wen   = 1'b0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    case (dec_op)
      OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU: begin
        dec_reg1  = rs_val;
        dec_reg2  = rt_val;
        dec_waddr = rd;
        dec_wen   = 1'b1;
        use_rs    = 1'b1;
        use_rt    = 1'b1;
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        dec_reg1  = {27'b0, sa};
        dec_reg2  = rt_val;
        dec_waddr = rd;
        dec_wen   = 1'b1;
        use_rt    = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        dec_reg1  = rs_val;
        dec_reg2  = {{16{imm[15]}}, imm};
        dec_waddr = rt;
        dec_wen   = 1'b1;
        use_rs    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_reg1  = rs_val;
        dec_reg2  = {16'h0, imm};
        dec_waddr = rt;
        dec_wen   = 1'b1;
        use_rs    = 1'b1;
      end
      OP_LUI: begin
        dec_reg2  = {imm, 16'h0};
        dec_waddr = rt;
        dec_wen   = 1'b1;
      end
      OP_JAL: begin
        dec_reg1  = slot_pc + 32'd8;
        dec_waddr = 5'd31;
        dec_wen   = 1'b1;
      end
      default: ;
    endcase
  end

  assign dec_we = dec_wen && (dec_waddr != 5'd0);

  logic hazard;
  logic advance;
  logic stage_ready;
  logic accept;

  logic        ex_valid_q;
  logic [31:0] ex_pc_q;
  Oper_t       ex_op_q;
  logic [31:0] ex_reg1_q;
  logic [31:0] ex_reg2_q;
  logic        ex_we_q;
  logic [4:0]  ex_waddr_q;

  assign hazard      = (use_rs && rs_load) || (use_rt && rt_load);
  assign advance     = slot_valid && !hazard && (!ex_valid_q || bus.ex_ready);
  assign stage_ready = !flush && (!slot_valid || advance);
  assign accept      = bus.if_valid && stage_ready;

  assign bus.id_ready = stage_ready;
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_pc    = ex_pc_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_reg1  = ex_reg1_q;
  assign bus.ex_reg2  = ex_reg2_q;
  assign bus.ex_we    = ex_we_q;
  assign bus.ex_waddr = ex_waddr_q;

  // A same-cycle accept and advance simply overwrites the slot with the new instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      slot_pc    <= '0;
      slot_inst  <= '0;
    end else if (flush) begin
      slot_valid <= 1'b0;
    end else if (accept) begin
      slot_valid <= 1'b1;
      slot_pc    <= bus.if_pc;
      slot_inst  <= bus.if_inst;
    end else if (advance) begin
      slot_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_op_q    <= OP_INVALID;
      ex_reg1_q  <= '0;
      ex_reg2_q  <= '0;
      ex_we_q    <= 1'b0;
      ex_waddr_q <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      ex_valid_q <= 1'b1;
      ex_pc_q    <= slot_pc;
      ex_op_q    <= dec_op;
      ex_reg1_q  <= dec_reg1;
      ex_reg2_q  <= dec_reg2;
      ex_we_q    <= dec_we;
      ex_waddr_q <= dec_waddr;
    end else if (bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (slot_valid && hazard && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_id_stage.sv
// Bench for cpu_id_stage: directed decode table, hand-written hazard/flush/reset sequences,
// and a randomized run against a transaction-level reference model.
module tb_cpu_id_stage;
  import cpu_id_pkg::*;

  localparam int NF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              flush;
  logic [4:0]        raddr1, raddr2, raddr1_s, raddr2_s;
  logic [31:0]       reg1, reg2, reg1_s, reg2_s;
  logic [NF-1:0]     fwd_we;
  logic [NF-1:0]     fwd_is_load;
  logic [NF*5-1:0]   fwd_waddr;
  logic [NF*32-1:0]  fwd_wdata;
  logic [15:0]       stall_cnt;
  logic [1:0]        stall_cnt_sat;
  logic [31:0]       rf [32];

  int checks = 0;
  int errors = 0;

  cpu_id_stage_if bus ();
  cpu_id_stage_if bus_s ();

  assign bus_s.if_valid = bus.if_valid;
  assign bus_s.if_pc    = bus.if_pc;
  assign bus_s.if_inst  = bus.if_inst;
  assign bus_s.ex_ready = bus.ex_ready;

  always_comb reg1   = rf[raddr1];
  always_comb reg2   = rf[raddr2];
  always_comb reg1_s = rf[raddr1_s];
  always_comb reg2_s = rf[raddr2_s];

  cpu_id_stage #(.NUM_FWD(NF), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.master),
    .reg_raddr1(raddr1), .reg_raddr2(raddr2), .reg1_i(reg1), .reg2_i(reg2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_is_load(fwd_is_load), .stall_cnt(stall_cnt)
  );

  cpu_id_stage #(.NUM_FWD(NF), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_s.master),
    .reg_raddr1(raddr1_s), .reg_raddr2(raddr2_s), .reg1_i(reg1_s), .reg2_i(reg2_s),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_is_load(fwd_is_load), .stall_cnt(stall_cnt_sat)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        f0_we;
    logic [4:0]  f0_addr;
    logic [31:0] f0_data;
    logic        f1_we;
    logic [4:0]  f1_addr;
    logic [31:0] f1_data;
    logic        f1_load;
    Oper_t       op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        we;
    logic [4:0]  waddr;
  } vec_t;

  typedef struct {
    Oper_t       op;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        we;
    logic [4:0]  waddr;
    bit          use_rs;
    bit          use_rt;
  } dec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  vec_t  vecs [14];
  slot_t slot_q [$];
  dec_t  ex_q [$];
  int    m_cnt;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                                input bit rdy, input bit fl);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
    bus.ex_ready = rdy;
    flush        = fl;
  endtask

  task automatic set_fwd(input int ch, input bit we, input logic [4:0] a, input logic [31:0] d, input bit ld);
    fwd_we[ch]          = we;
    fwd_waddr[5*ch +: 5] = a;
    fwd_wdata[32*ch +: 32] = d;
    fwd_is_load[ch]     = ld;
  endtask

  task automatic clear_fwd();
    fwd_we      = '0;
    fwd_waddr   = '0;
    fwd_wdata   = '0;
    fwd_is_load = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_ex_valid"}, bus.ex_valid, 1'b0);
    check_output({tag, "_ex_pc"}, bus.ex_pc, 32'h0);
    check_output({tag, "_ex_op"}, 32'(bus.ex_op), 32'(OP_INVALID));
    check_output({tag, "_ex_reg1"}, bus.ex_reg1, 32'h0);
    check_output({tag, "_ex_reg2"}, bus.ex_reg2, 32'h0);
    check_output({tag, "_ex_we"}, bus.ex_we, 1'b0);
    check_output({tag, "_ex_waddr"}, bus.ex_waddr, 5'd0);
    check_output({tag, "_stall_cnt"}, stall_cnt, 16'd0);
    check_output({tag, "_stall_cnt_sat"}, stall_cnt_sat, 2'd0);
  endtask

  task automatic check_ex(input string tag, input logic [31:0] pc, input Oper_t op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic we, input logic [4:0] waddr);
    check_output({tag, "_ex_valid"}, bus.ex_valid, 1'b1);
    check_output({tag, "_ex_pc"}, bus.ex_pc, pc);
    check_output({tag, "_ex_op"}, 32'(bus.ex_op), 32'(op));
    check_output({tag, "_ex_reg1"}, bus.ex_reg1, r1);
    check_output({tag, "_ex_reg2"}, bus.ex_reg2, r2);
    check_output({tag, "_ex_we"}, bus.ex_we, we);
    check_output({tag, "_ex_waddr"}, bus.ex_waddr, waddr);
  endtask

  // Reference operand lookup: the first (youngest) writing channel wins, else the regfile.
  function automatic logic [32:0] resolve(input logic [4:0] src);
    if (src == 5'd0) return 33'd0;
    for (int i = 0; i < NF; i++)
      if (fwd_we[i] && fwd_waddr[5*i +: 5] == src) return {fwd_is_load[i], fwd_wdata[32*i +: 32]};
    return {1'b0, rf[src]};
  endfunction

  function automatic dec_t model_decode(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
    dec_t d;
    logic [5:0] opc = inst[31:26];
    logic [5:0] fn  = inst[5:0];
    logic [15:0] im = inst[15:0];
    d = '{OP_INVALID, pc, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
    if (opc == 6'h00) begin
      case (fn)
        6'h21: d.op = OP_ADDU;  6'h23: d.op = OP_SUBU;
        6'h24: d.op = OP_AND;   6'h25: d.op = OP_OR;
        6'h26: d.op = OP_XOR;   6'h27: d.op = OP_NOR;
        6'h2A: d.op = OP_SLT;   6'h2B: d.op = OP_SLTU;
        6'h00: d.op = OP_SLL;   6'h02: d.op = OP_SRL;
        6'h03: d.op = OP_SRA;   default: d.op = OP_INVALID;
      endcase
      if (d.op == OP_SLL || d.op == OP_SRL || d.op == OP_SRA) begin
        d.r1 = 32'(inst[10:6]); d.r2 = b; d.waddr = inst[15:11]; d.we = 1'b1; d.use_rt = 1'b1;
      end else if (d.op != OP_INVALID) begin
        d.r1 = a; d.r2 = b; d.waddr = inst[15:11]; d.we = 1'b1; d.use_rs = 1'b1; d.use_rt = 1'b1;
      end
    end else begin
      case (opc)
        6'h09, 6'h0A, 6'h0B, 6'h23: begin
          d.op = (opc == 6'h09) ? OP_ADDIU : (opc == 6'h0A) ? OP_SLTI : (opc == 6'h0B) ? OP_SLTIU : OP_LW;
          d.r1 = a; d.r2 = 32'(signed'(im)); d.waddr = inst[20:16]; d.we = 1'b1; d.use_rs = 1'b1;
        end
        6'h0C, 6'h0D, 6'h0E: begin
          d.op = (opc == 6'h0C) ? OP_ANDI : (opc == 6'h0D) ? OP_ORI : OP_XORI;
          d.r1 = a; d.r2 = 32'(im); d.waddr = inst[20:16]; d.we = 1'b1; d.use_rs = 1'b1;
        end
        6'h0F: begin
          d.op = OP_LUI; d.r2 = im * 32'h10000; d.waddr = inst[20:16]; d.we = 1'b1;
        end
        6'h02: d.op = OP_J;
        6'h03: begin
          d.op = OP_JAL; d.r1 = pc + 32'd8; d.waddr = 5'd31; d.we = 1'b1;
        end
        default: ;
      endcase
    end
    if (d.waddr == 5'd0) d.we = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] rs = 32'($urandom_range(0, 7));
    logic [31:0] rt = 32'($urandom_range(0, 7));
    logic [31:0] rd = 32'($urandom_range(0, 7));
    logic [31:0] sa = 32'($urandom_range(0, 31));
    logic [31:0] im = 32'($urandom_range(0, 65535));
    logic [31:0] fn;
    logic [31:0] op;
    case ($urandom_range(0, 9))
      0, 8, 9: begin
        case ($urandom_range(0, 7))
          0: fn = 32'h21; 1: fn = 32'h23; 2: fn = 32'h24; 3: fn = 32'h25;
          4: fn = 32'h26; 5: fn = 32'h27; 6: fn = 32'h2A; default: fn = 32'h2B;
        endcase
        return (rs << 21) | (rt << 16) | (rd << 11) | fn;
      end
      1: begin
        fn = 32'($urandom_range(0, 2));
        if (fn == 32'd1) fn = 32'd3;
        return (rt << 16) | (rd << 11) | (sa << 6) | fn;
      end
      2: begin
        case ($urandom_range(0, 3))
          0: op = 32'h09; 1: op = 32'h0A; 2: op = 32'h0B; default: op = 32'h23;
        endcase
        return (op << 26) | (rs << 21) | (rt << 16) | im;
      end
      3: begin
        op = 32'($urandom_range(12, 14));
        return (op << 26) | (rs << 21) | (rt << 16) | im;
      end
      4: return (32'h0F << 26) | (rt << 16) | im;
      5: return (32'h02 << 26) | (32'($urandom) & 32'h03FF_FFFF);
      6: return (32'h03 << 26) | (32'($urandom) & 32'h03FF_FFFF);
      default: return 32'($urandom);
    endcase
  endfunction

  logic [32:0] ra, rb;
  dec_t        md;
  slot_t       ms;
  bit          hz, adv, rdy;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hBAD0_0000;
    clear_fwd();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_reset("reset");
    settle();
    check_output("reset_id_ready", bus.id_ready, 1'b1);

    vecs[0]  = '{32'h24010005, 32'h400, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_ADDIU, 32'h0,    32'h5,        1'b1, 5'd1};
    vecs[1]  = '{32'h00832821, 32'h404, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_ADDU,  32'h1004, 32'h1003,     1'b1, 5'd5};
    vecs[2]  = '{32'h00030080, 32'h408, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_SLL,   32'h2,    32'h1003,     1'b0, 5'd0};
    vecs[3]  = '{32'h3C071234, 32'h40C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_LUI,   32'h0,    32'h12340000, 1'b1, 5'd7};
    vecs[4]  = '{32'h30228001, 32'h410, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_ANDI,  32'h1001, 32'h00008001, 1'b1, 5'd2};
    vecs[5]  = '{32'h2822FFFF, 32'h414, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_SLTI,  32'h1001, 32'hFFFFFFFF, 1'b1, 5'd2};
    vecs[6]  = '{32'h0C000040, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_JAL,   32'h108,  32'h0,        1'b1, 5'd31};
    vecs[7]  = '{32'hFC221234, 32'h41C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_INVALID, 32'h0,  32'h0,        1'b0, 5'd0};
    vecs[8]  = '{32'h00000821, 32'h420, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0, 1'b0, OP_ADDU, 32'h0,    32'h0,        1'b1, 5'd1};
    vecs[9]  = '{32'h00630821, 32'h424, 1'b1, 5'd3, 32'h7, 1'b1, 5'd3, 32'h9, 1'b1, OP_ADDU,  32'h7,    32'h7,        1'b1, 5'd1};
    vecs[10] = '{32'h08000010, 32'h428, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_J,     32'h0,    32'h0,        1'b0, 5'd0};
    vecs[11] = '{32'h000537C3, 32'h42C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_SRA,   32'h1F,   32'h1005,     1'b1, 5'd6};
    vecs[12] = '{32'h3909FFFF, 32'h430, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_XORI,  32'h1008, 32'h0000FFFF, 1'b1, 5'd9};
    vecs[13] = '{32'h8FA4FFFC, 32'h434, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, OP_LW,    32'h101D, 32'hFFFFFFFC, 1'b1, 5'd4};

    foreach (vecs[k]) begin
      clear_fwd();
      set_fwd(0, vecs[k].f0_we, vecs[k].f0_addr, vecs[k].f0_data, 1'b0);
      set_fwd(1, vecs[k].f1_we, vecs[k].f1_addr, vecs[k].f1_data, vecs[k].f1_load);
      apply_stimulus(1'b1, vecs[k].pc, vecs[k].inst, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check_ex($sformatf("vec%0d", k), vecs[k].pc, vecs[k].op, vecs[k].r1, vecs[k].r2, vecs[k].we, vecs[k].waddr);
      tick();
    end
    clear_fwd();
    check_output("table_no_stall", stall_cnt, 16'd0);

    // Back-to-back ADDIU with $1 forwarded on channel 0 in the second decode cycle.
    apply_stimulus(1'b1, 32'h200, 32'h24010005, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h204, 32'h24220003, 1'b1, 1'b0);
    settle();
    check_output("b2b_id_ready", bus.id_ready, 1'b1);
    tick();
    check_ex("b2b_first", 32'h200, OP_ADDIU, 32'h0, 32'h5, 1'b1, 5'd1);
    set_fwd(0, 1'b1, 5'd1, 32'h5, 1'b0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check_ex("b2b_second", 32'h204, OP_ADDIU, 32'h5, 32'h3, 1'b1, 5'd2);
    check_output("b2b_stall_cnt", stall_cnt, 16'd0);
    clear_fwd();
    tick();

    // Load-use on $4 for one cycle, then the load resolves to 0xDEAD.
    apply_stimulus(1'b1, 32'h300, 32'h00802821, 1'b1, 1'b0);
    tick();
    set_fwd(0, 1'b1, 5'd4, 32'h1234, 1'b1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    settle();
    check_output("lu_id_ready", bus.id_ready, 1'b0);
    tick();
    check_output("lu_ex_valid", bus.ex_valid, 1'b0);
    check_output("lu_stall_cnt", stall_cnt, 16'd1);
    set_fwd(0, 1'b1, 5'd4, 32'hDEAD, 1'b0);
    settle();
    check_output("lu_resolved_ready", bus.id_ready, 1'b1);
    tick();
    check_ex("lu_done", 32'h300, OP_ADDU, 32'hDEAD, 32'h0, 1'b1, 5'd5);
    check_output("lu_stall_cnt_after", stall_cnt, 16'd1);
    clear_fwd();
    tick();

    // Older load on channel 1 stalls until a younger non-load match masks it.
    apply_stimulus(1'b1, 32'h310, 32'h00630821, 1'b1, 1'b0);
    tick();
    set_fwd(1, 1'b1, 5'd3, 32'h9, 1'b1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    settle();
    check_output("prio_id_ready", bus.id_ready, 1'b0);
    tick();
    check_output("prio_ex_valid", bus.ex_valid, 1'b0);
    check_output("prio_stall_cnt", stall_cnt, 16'd2);
    check_output("prio_stall_cnt_sat", stall_cnt_sat, 2'd2);
    set_fwd(0, 1'b1, 5'd3, 32'h7, 1'b0);
    settle();
    check_output("prio_mask_ready", bus.id_ready, 1'b1);
    tick();
    check_ex("prio_done", 32'h310, OP_ADDU, 32'h7, 32'h7, 1'b1, 5'd1);
    clear_fwd();
    tick();

    // Backpressure for three cycles with a flush in the second.
    apply_stimulus(1'b1, 32'h400, 32'h24010005, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h404, 32'h3C071234, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h408, 32'h24220003, 1'b0, 1'b0);
    settle();
    check_output("bp1_id_ready", bus.id_ready, 1'b0);
    tick();
    check_ex("bp1_hold", 32'h400, OP_ADDIU, 32'h0, 32'h5, 1'b1, 5'd1);
    apply_stimulus(1'b1, 32'h408, 32'h24220003, 1'b0, 1'b1);
    settle();
    check_output("bp2_flush_id_ready", bus.id_ready, 1'b0);
    tick();
    check_output("bp2_ex_valid", bus.ex_valid, 1'b0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check_output("bp3_slot_empty", bus.id_ready, 1'b1);
    tick();
    check_output("bp3_ex_valid", bus.ex_valid, 1'b0);
    apply_stimulus(1'b1, 32'h100, 32'h0C000040, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check_ex("bp_jal", 32'h100, OP_JAL, 32'h108, 32'h0, 1'b1, 5'd31);
    tick();

    // Counter saturation on the 2-bit instance, then reset in the middle of the stall.
    do_reset();
    apply_stimulus(1'b1, 32'h500, 32'h00802821, 1'b1, 1'b0);
    tick();
    set_fwd(0, 1'b1, 5'd4, 32'h0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (5) tick();
    check_output("sat_stall_cnt", stall_cnt, 16'd5);
    check_output("sat_stall_cnt_sat", stall_cnt_sat, 2'd3);
    check_output("sat_ex_valid", bus.ex_valid, 1'b0);
    rst_n = 1'b0;
    tick();
    check_reset("midreset");
    rst_n = 1'b1;
    clear_fwd();
    settle();
    check_output("midreset_id_ready", bus.id_ready, 1'b1);
    tick();

    // Randomized run against the transaction-level model.
    do_reset();
    slot_q.delete();
    ex_q.delete();
    m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 32'($urandom) & 32'hFFFF_FFFC, gen_inst(),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      for (int ch = 0; ch < NF; ch++)
        set_fwd(ch, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom),
                $urandom_range(0, 3) == 0);
      settle();
      hz  = 1'b0;
      adv = 1'b0;
      if (slot_q.size() > 0) begin
        ms  = slot_q[0];
        ra  = resolve(ms.inst[25:21]);
        rb  = resolve(ms.inst[20:16]);
        md  = model_decode(ms.inst, ms.pc, ra[31:0], rb[31:0]);
        hz  = (md.use_rs && ra[32]) || (md.use_rt && rb[32]);
        adv = !hz && (ex_q.size() == 0 || bus.ex_ready);
      end
      rdy = !flush && (slot_q.size() == 0 || adv);
      check_output("rnd_id_ready", bus.id_ready, rdy);
      if (slot_q.size() > 0 && hz) m_cnt++;
      if (flush) begin
        slot_q.delete();
        ex_q.delete();
      end else begin
        if (ex_q.size() > 0 && (adv || bus.ex_ready)) ex_q.delete();
        if (adv) begin
          ex_q.push_back(md);
          void'(slot_q.pop_front());
        end
        if (bus.if_valid && rdy) slot_q.push_back('{bus.if_pc, bus.if_inst});
      end
      tick();
      check_output("rnd_ex_valid", bus.ex_valid, ex_q.size() != 0);
      check_output("rnd_sat_ex_valid", bus_s.ex_valid, ex_q.size() != 0);
      if (ex_q.size() != 0)
        check_ex("rnd", ex_q[0].pc, ex_q[0].op, ex_q[0].r1, ex_q[0].r2, ex_q[0].we, ex_q[0].waddr);
      check_output("rnd_stall_cnt", stall_cnt, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check_output("rnd_stall_cnt_sat", stall_cnt_sat, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
